// File: rtl/field_cfg_loader_if.sv
// Config request type shared with FCL_controller, and the loader's handshake bundle
// (start/request, ROM read port, field memory write port).
package fcl_pkg;
   typedef enum logic [1:0] {
      NO_REQ = 2'd0,
      CFG_1  = 2'd1,
      CFG_2  = 2'd2
   } load_cfg_req_t;
endpackage

interface field_cfg_loader_if
   import fcl_pkg::*;
#(
   parameter int FIELD_W = 32,
   parameter int FIELD_H = 32
);
   localparam int ROW_AW = $clog2(FIELD_H);
   localparam int ROM_AW = $clog2(2*FIELD_H);

   logic                  i_go;
   load_cfg_req_t         i_cfg_req;
   logic                  o_is_loading;
   logic                  o_done;
   logic                  o_rom_rd;
   logic [ROM_AW-1:0]     o_rom_addr;
   logic [FIELD_W-1:0]    i_rom_data;
   logic                  o_wr_en;
   logic [ROW_AW-1:0]     o_wr_addr;
   logic [FIELD_W-1:0]    o_wr_data;
   logic                  i_wr_ready;

   modport master (
      input  i_go, i_cfg_req, i_rom_data, i_wr_ready,
      output o_is_loading, o_done, o_rom_rd, o_rom_addr, o_wr_en, o_wr_addr, o_wr_data
   );

   modport slave (
      output i_go, i_cfg_req, i_rom_data, i_wr_ready,
      input  o_is_loading, o_done, o_rom_rd, o_rom_addr, o_wr_en, o_wr_addr, o_wr_data
   );
endinterface

// File: rtl/field_cfg_loader.sv
// Copies one of two preset configurations, row by row, from the config ROM into the
// field memory write port. Three cycles per row (READ, WAIT, WRITE) plus write stalls.
module field_cfg_loader
   import fcl_pkg::*;
#(
   parameter int FIELD_W = 32,
   parameter int FIELD_H = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   field_cfg_loader_if.master  bus
);
   localparam int ROW_AW = $clog2(FIELD_H);
   localparam int ROM_AW = $clog2(2*FIELD_H);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE
   } state_t;

   state_t              state_q, state_d;
   logic                cfg_q, cfg_d;
   logic [ROW_AW-1:0]   row_q, row_d;
   logic [FIELD_W-1:0]  buf_q, buf_d;
   logic                done_q, done_d;
   logic                last_row;

   assign last_row = (row_q == ROW_AW'(FIELD_H-1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cfg_q   <= 1'b0;
         row_q   <= '0;
         buf_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         row_q   <= row_d;
         buf_q   <= buf_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      row_d   = row_q;
      buf_d   = buf_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Request is sampled only here; later changes have no effect on the copy.
            if (bus.i_go && (bus.i_cfg_req != NO_REQ)) begin
               cfg_d   = (bus.i_cfg_req == CFG_2);
               row_d   = '0;
               state_d = S_READ;
            end
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT: begin
            buf_d   = bus.i_rom_data;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (bus.i_wr_ready) begin
               if (last_row) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  row_d   = row_q + ROW_AW'(1);
                  state_d = S_READ;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Second config sits directly above the first in the ROM.
   assign bus.o_rom_addr   = cfg_q ? (ROM_AW'(FIELD_H) + ROM_AW'(row_q)) : ROM_AW'(row_q);
   assign bus.o_is_loading = (state_q != S_IDLE);
   assign bus.o_rom_rd     = (state_q == S_READ);
   assign bus.o_wr_en      = (state_q == S_WRITE);
   assign bus.o_wr_addr    = row_q;
   assign bus.o_wr_data    = buf_q;
   assign bus.o_done       = done_q;
endmodule

// File: tb/tb_field_cfg_loader.sv
// Bench for field_cfg_loader: table of load scenarios, hand-written corner sequences,
// and randomized ROM contents / write backpressure checked against a row-copy model.
module tb_field_cfg_loader;
   import fcl_pkg::*;

   localparam int W = 8;
   localparam int H = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   field_cfg_loader_if #(.FIELD_W(W), .FIELD_H(H)) bus ();

   field_cfg_loader #(.FIELD_W(W), .FIELD_H(H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [W-1:0] rom [2*H];
   int compared = 0;
   int mismatched = 0;

   // Observed behaviour, accumulated only by the monitor; tests work on deltas.
   int          load_cyc = 0, done_cnt = 0, done_bad = 0, stall_cyc = 0, stab_bad = 0;
   logic [15:0] wlog [$];
   int          raddr [$];
   bit          prev_load = 0, prev_stall = 0, rd_q = 0;
   logic [1:0]  pa = '0;
   logic [W-1:0] pd = '0;
   logic [2:0]  ra_q = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_is_loading) load_cyc++;
         if (bus.o_done) begin
            done_cnt++;
            if (bus.o_is_loading || !prev_load) done_bad++;
         end
         if (bus.o_wr_en && bus.i_wr_ready) wlog.push_back({6'd0, bus.o_wr_addr, bus.o_wr_data});
         if (bus.o_wr_en && !bus.i_wr_ready) stall_cyc++;
         if (prev_stall && !(bus.o_wr_en && bus.o_wr_addr == pa && bus.o_wr_data == pd)) stab_bad++;
         if (bus.o_rom_rd) raddr.push_back(int'(bus.o_rom_addr));
      end
      prev_load  = (bus.o_is_loading === 1'b1);
      prev_stall = rst_n && (bus.o_wr_en === 1'b1) && (bus.i_wr_ready === 1'b0);
      pa   = bus.o_wr_addr;
      pd   = bus.o_wr_data;
      rd_q = (bus.o_rom_rd === 1'b1);
      ra_q = bus.o_rom_addr;
   end

   // ROM answers in the cycle after the read strobe, garbage otherwise.
   always @(posedge clk) bus.i_rom_data <= rd_q ? rom[ra_q] : 8'($urandom);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Runs one copy and checks it against the model: row r receives rom[cfg*H + r].
   // Returns at the done cycle, before its closing edge, so a go may follow at once.
   task automatic run_load(input load_cfg_req_t cfg, input int stall_row, input int stall_len,
                           input bit mid_go, input bit rnd_ready, input int exp_cyc,
                           output logic [W-1:0] d0, output logic [W-1:0] dl);
      int base_w, base_r, base_l, base_d, base_s, base_db, base_sb, stalled, ecyc, cbase;
      bit timed_out;
      base_w = wlog.size();  base_r = raddr.size();  base_l = load_cyc;
      base_d = done_cnt;     base_s = stall_cyc;     base_db = done_bad;  base_sb = stab_bad;
      stalled = 0;  timed_out = 1;
      cbase = (cfg == CFG_2) ? H : 0;
      bus.i_go = 1'b1;  bus.i_cfg_req = cfg;  bus.i_wr_ready = 1'b1;
      tick();
      bus.i_go = 1'b0;
      bus.i_cfg_req = load_cfg_req_t'($urandom_range(0, 2));
      for (int cyc = 1; cyc < 300; cyc++) begin
         if (bus.o_done) begin
            timed_out = 0;
            break;
         end
         bus.i_go = 1'b0;
         if (mid_go && cyc == 5) begin
            bus.i_go = 1'b1;
            bus.i_cfg_req = (cfg == CFG_2) ? CFG_1 : CFG_2;
         end
         if (rnd_ready) bus.i_wr_ready = ($urandom_range(0, 2) != 0);
         else if (bus.o_wr_en && int'(bus.o_wr_addr) == stall_row && stalled < stall_len) begin
            bus.i_wr_ready = 1'b0;
            stalled++;
         end else bus.i_wr_ready = 1'b1;
         tick();
      end
      bus.i_go = 1'b0;
      chk("load_timeout", int'(timed_out), 0);
      @(negedge clk);
      #1;
      ecyc = (exp_cyc < 0) ? (3*H + (stall_cyc - base_s)) : exp_cyc;
      chk("write_count", wlog.size() - base_w, H);
      chk("rom_read_count", raddr.size() - base_r, H);
      for (int r = 0; r < H; r++) begin
         if (base_w + r < wlog.size()) begin
            chk("wr_addr", int'(wlog[base_w+r][9:8]), r);
            chk("wr_data", int'(wlog[base_w+r][7:0]), int'(rom[cbase+r]));
         end
         if (base_r + r < raddr.size()) chk("rom_addr", raddr[base_r+r], cbase + r);
      end
      chk("loading_cycles", load_cyc - base_l, ecyc);
      chk("done_pulses", done_cnt - base_d, 1);
      chk("done_alignment", done_bad - base_db, 0);
      chk("stall_stability", stab_bad - base_sb, 0);
      d0 = (wlog.size() > base_w) ? wlog[base_w][7:0] : 'x;
      dl = (wlog.size() >= base_w + H) ? wlog[base_w+H-1][7:0] : 'x;
   endtask

   typedef struct {
      load_cfg_req_t cfg;
      int            stall_row;
      int            stall_len;
      bit            mid_go;
      int            exp_cyc;
      logic [W-1:0]  exp_d0;
      logic [W-1:0]  exp_dl;
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [W-1:0] d0, dl;
      int bw, bd;
      vecs[0] = '{CFG_1, -1, 0, 1'b0, 12, 8'h11, 8'h44};
      vecs[1] = '{CFG_2, -1, 0, 1'b0, 12, 8'hA1, 8'hA4};
      vecs[2] = '{CFG_1,  2, 5, 1'b0, 17, 8'h11, 8'h44};
      vecs[3] = '{CFG_1, -1, 0, 1'b1, 12, 8'h11, 8'h44};
      vecs[4] = '{CFG_2,  0, 3, 1'b0, 15, 8'hA1, 8'hA4};
      for (int i = 0; i < H; i++) begin
         rom[i]   = 8'(8'h11 * (i + 1));
         rom[H+i] = 8'(8'hA1 + i);
      end

      bus.i_go = 1'b0;  bus.i_cfg_req = NO_REQ;  bus.i_wr_ready = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_is_loading", int'(bus.o_is_loading), 0);
      chk("rst_done", int'(bus.o_done), 0);
      chk("rst_rom_rd", int'(bus.o_rom_rd), 0);
      chk("rst_wr_en", int'(bus.o_wr_en), 0);
      chk("rst_rom_addr", int'(bus.o_rom_addr), 0);
      chk("rst_wr_addr", int'(bus.o_wr_addr), 0);
      chk("rst_wr_data", int'(bus.o_wr_data), 0);
      rst_n = 1'b1;
      tick();

      // Back-to-back: each load starts in the done cycle of the previous one.
      for (int v = 0; v < 5; v++) begin
         run_load(vecs[v].cfg, vecs[v].stall_row, vecs[v].stall_len, vecs[v].mid_go, 1'b0,
                  vecs[v].exp_cyc, d0, dl);
         chk("vec_first_row", int'(d0), int'(vecs[v].exp_d0));
         chk("vec_last_row", int'(dl), int'(vecs[v].exp_dl));
      end

      // go with NO_REQ must be ignored.
      tick();
      bw = raddr.size();
      bus.i_go = 1'b1;  bus.i_cfg_req = NO_REQ;
      tick();
      bus.i_go = 1'b0;
      tick();
      tick();
      chk("noreq_is_loading", int'(bus.o_is_loading), 0);
      chk("noreq_rom_reads", raddr.size() - bw, 0);

      // Reset in row 1 WRITE: abort without done, row 0 stays written.
      bw = wlog.size();  bd = done_cnt;
      bus.i_go = 1'b1;  bus.i_cfg_req = CFG_1;  bus.i_wr_ready = 1'b1;
      tick();
      bus.i_go = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.o_wr_en && bus.o_wr_addr == 2'd1) break;
         tick();
      end
      chk("rst_mid_reached_row1", int'(bus.o_wr_en && bus.o_wr_addr == 2'd1), 1);
      bus.i_wr_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("rst_mid_is_loading", int'(bus.o_is_loading), 0);
      chk("rst_mid_wr_en", int'(bus.o_wr_en), 0);
      chk("rst_mid_done", int'(bus.o_done), 0);
      chk("rst_mid_wr_addr", int'(bus.o_wr_addr), 0);
      rst_n = 1'b1;
      bus.i_wr_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      #1;
      chk("rst_mid_no_done", done_cnt - bd, 0);
      chk("rst_mid_rows_kept", wlog.size() - bw, 1);
      run_load(CFG_1, -1, 0, 1'b0, 1'b0, 12, d0, dl);
      chk("after_rst_first_row", int'(d0), 32'h11);

      // Random ROM contents, config and write backpressure.
      for (int n = 0; n < 8; n++) begin
         tick();
         for (int i = 0; i < 2*H; i++) rom[i] = 8'($urandom);
         run_load(($urandom_range(0, 1) != 0) ? CFG_2 : CFG_1, -1, 0, n[0], 1'b1, -1, d0, dl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
